purse_deploy_ctrl: RTL and testbench
====================================

Name: purse_deploy_ctrl

Overview:
Sequential economy controller for the battle screen. It accumulates money on a periodic income tick, saturating at the level-dependent purse cap. It arbitrates army-deploy and purse-upgrade purchases and tracks a per-slot deploy cooldown. All stat tables are parametrised flattened input buses, so slot count, level count and money width scale without RTL edits.

Parameters:
MONEY_W, 15, money/cost/cap width in bits
NUM_SLOTS, 8, number of army deploy slots
SLOT_W, 3, width of the slot index; NUM_SLOTS must be ≤ 2**SLOT_W
LEVELS, 8, number of purse levels
LVL_W, 3, width of the level register
CD_W, 8, cooldown width, counted in ticks
TICK_DIV, 10000000, clk cycles per income tick
INC_BASE, 1, income per tick at level 0
INC_STEP, 1, extra income per tick per level

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset, sampled on rising clk
enable  in  1  game running; low freezes all state
start  in  1  one-cycle pulse; clears money, level and cooldowns for a new battle
deploy_req  in  1  deploy request, sampled every cycle while high
deploy_slot  in  SLOT_W  slot for deploy_req
upgrade_req  in  1  purse upgrade request
cost_tbl  in  NUM_SLOTS*MONEY_W  slot i cost at bits [i*MONEY_W +: MONEY_W]
cd_tbl  in  NUM_SLOTS*CD_W  slot i cooldown in ticks
max_tbl  in  LEVELS*MONEY_W  purse cap per level
upg_tbl  in  LEVELS*MONEY_W  upgrade price per level
money  out  MONEY_W  current money
level  out  LVL_W  current purse level
deploy_ack / deploy_nack  out  1  one-cycle result pulses
upgrade_ack / upgrade_nack  out  1  one-cycle result pulses
slot_ready  out  NUM_SLOTS  bit i = cooldown[i]==0 and money ≥ cost[i]
upgrade_ready  out  1  level<LEVELS-1 and money ≥ upg_tbl[level]
tick  out  1  one-cycle income tick strobe

Behaviour:
- Reset (rst_n=0 at a clk edge) overrides everything, including mid-operation:
  - money=0, level=0, all cooldowns=0, tick counter=0.
  - All ack/nack/tick outputs 0.
  - slot_ready and upgrade_ready follow from register values and table inputs.
- start=1 (with rst_n=1) has the same effect as reset. It takes priority over requests and tick in that cycle.
- States:
  - RUN: enable=1.
  - HOLD: enable=0. Counters, money and cooldowns are frozen. Requests are ignored: no ack and no nack.
- Tick:
  - Counter runs 0..TICK_DIV-1 in RUN. tick=1 in the cycle it wraps to 0.
  - On tick: income = INC_BASE + level*INC_STEP, and every nonzero cooldown decrements by 1.
- Request evaluation uses registered state at the sampling edge. Results are registered, so ack/nack appear exactly 1 cycle after the request.
- Deploy accept condition: cooldown[slot]==0, money ≥ cost[slot], and slot < NUM_SLOTS.
  - Otherwise deploy_nack.
  - On accept, cooldown[slot] loads cd_tbl[slot]; this load overrides the tick decrement for that slot in the same cycle.
- Upgrade accept condition: level < LEVELS-1 and money ≥ upg_tbl[level]. Otherwise upgrade_nack.
  - On accept, level increments by 1.
- Simultaneous deploy_req and upgrade_req: deploy has priority and is evaluated; upgrade gets nack in that cycle.
- Money update per cycle:
  - money_next = min(money − spend + (tick ? income : 0), max_tbl[level_next]).
  - Computed at MONEY_W+2 bits.
  - spend never exceeds money because of the accept rules, so there is no underflow.
  - Spend and income in the same cycle both apply.
- Holding a request high produces one evaluation per cycle, each with an ack or nack.

Test Plan:
- Reset: TICK_DIV=4, rst_n=0 for 2 cycles with enable=1 and requests high -> money=0, level=0, all pulses 0, slot_ready=0 (cost0=75).
- Income/saturation: INC_BASE=10, max_tbl[0]=150, enable 80 cycles -> tick every 4th cycle, money reaches 150 at tick 15 and stays 150.
- Deploy/cooldown:
  - Setup: money=150, cost0=75, cd0=3, deploy slot0.
  - Expect: deploy_ack next cycle, money=75, slot_ready[0]=0.
  - Re-request before 3 ticks -> deploy_nack, money unchanged.
  - After 3 ticks -> slot_ready[0]=1.
- Upgrade:
  - money=100, upg_tbl[0]=100 -> upgrade_ack, level=1, money=0, cap becomes max_tbl[1]=300.
  - At level 7 -> upgrade_nack, level stays 7.
- Collision: money=100, deploy slot0 (cost 75) + upgrade_req in a tick cycle with income 10 -> deploy_ack, upgrade_nack, money=35.
- Freeze/start: enable=0 for 20 cycles -> money, tick counter and cooldowns unchanged, no pulses; start pulse with money=150, level=2 -> money=0, level=0 next cycle.

Source files
------------

// File: rtl/purse_deploy_ctrl.sv
// Battle-screen economy: periodic income up to a level-dependent purse cap,
// deploy/upgrade purchase arbitration and per-slot deploy cooldowns.
module purse_deploy_ctrl #(
  parameter int MONEY_W   = 15,
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 3,
  parameter int LEVELS    = 8,
  parameter int LVL_W     = 3,
  parameter int CD_W      = 8,
  parameter int TICK_DIV  = 10000000,
  parameter int INC_BASE  = 1,
  parameter int INC_STEP  = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           start,
  input  logic                           deploy_req,
  input  logic [SLOT_W-1:0]              deploy_slot,
  input  logic                           upgrade_req,
  input  logic [NUM_SLOTS*MONEY_W-1:0]   cost_tbl,
  input  logic [NUM_SLOTS*CD_W-1:0]      cd_tbl,
  input  logic [LEVELS*MONEY_W-1:0]      max_tbl,
  input  logic [LEVELS*MONEY_W-1:0]      upg_tbl,
  output logic [MONEY_W-1:0]             money,
  output logic [LVL_W-1:0]               level,
  output logic                           deploy_ack,
  output logic                           deploy_nack,
  output logic                           upgrade_ack,
  output logic                           upgrade_nack,
  output logic [NUM_SLOTS-1:0]           slot_ready,
  output logic                           upgrade_ready,
  output logic                           tick
);

  // state   | meaning
  // ST_RUN  | enable=1: tick counter runs, requests evaluated
  // ST_HOLD | enable=0: everything frozen, requests ignored
  typedef enum logic {ST_RUN, ST_HOLD} mode_e;

  localparam int SUM_W = MONEY_W + 2;
  localparam int CNT_W = $clog2(TICK_DIV + 1);

  mode_e              mode;
  logic [MONEY_W-1:0] money_q, money_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [CD_W-1:0]    cd_q [NUM_SLOTS];
  logic [CD_W-1:0]    cd_d [NUM_SLOTS];
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dack_q, dack_d, dnack_q, dnack_d;
  logic               uack_q, uack_d, unack_q, unack_d;

  logic               act, tick_ev, slot_ok, dep_ok, upg_can, upg_ok;
  logic [MONEY_W-1:0] cost_sel, upg_price, spend, cap;
  logic [CD_W-1:0]    cd_load, cd_cur;
  logic [LVL_W-1:0]   level_nxt;
  logic [SUM_W-1:0]   income, sum;

  assign mode = enable ? ST_RUN : ST_HOLD;

  always_comb begin
    cost_sel = '0;
    cd_load  = '0;
    cd_cur   = '0;
    slot_ok  = 1'b0;
    // slot index may address past NUM_SLOTS; those requests are refused
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (deploy_slot == SLOT_W'(i)) begin
        slot_ok  = 1'b1;
        cost_sel = cost_tbl[i*MONEY_W +: MONEY_W];
        cd_load  = cd_tbl[i*CD_W +: CD_W];
        cd_cur   = cd_q[i];
      end
    end

    act       = (mode == ST_RUN) && !start;
    tick_ev   = act && (cnt_q == CNT_W'(TICK_DIV - 1));
    upg_price = upg_tbl[level_q*MONEY_W +: MONEY_W];
    upg_can   = (level_q < LVL_W'(LEVELS - 1)) && (money_q >= upg_price);
    dep_ok    = act && deploy_req && slot_ok && (cd_cur == '0) && (money_q >= cost_sel);
    upg_ok    = act && upgrade_req && !deploy_req && upg_can;

    level_nxt = level_q + LVL_W'(upg_ok);
    spend     = dep_ok ? cost_sel : (upg_ok ? upg_price : '0);
    income    = SUM_W'(INC_BASE) + SUM_W'(level_q) * SUM_W'(INC_STEP);
    sum       = {2'b00, money_q} - {2'b00, spend} + (tick_ev ? income : '0);
    cap       = max_tbl[level_nxt*MONEY_W +: MONEY_W];

    money_d = (sum > {2'b00, cap}) ? cap : sum[MONEY_W-1:0];
    level_d = level_nxt;
    cnt_d   = cnt_q;
    if (act) cnt_d = tick_ev ? '0 : cnt_q + 1'b1;

    // a fresh load on deploy wins over the tick decrement of the same slot
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cd_d[i] = cd_q[i];
      if (tick_ev && (cd_q[i] != '0)) cd_d[i] = cd_q[i] - 1'b1;
      if (dep_ok && (deploy_slot == SLOT_W'(i))) cd_d[i] = cd_load;
    end

    dack_d  = dep_ok;
    dnack_d = act && deploy_req && !dep_ok;
    uack_d  = upg_ok;
    unack_d = act && upgrade_req && !upg_ok;

    if (start) begin
      money_d = '0;
      level_d = '0;
      cnt_d   = '0;
      for (int i = 0; i < NUM_SLOTS; i++) cd_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      money_q <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) cd_q[i] <= '0;
      dack_q  <= 1'b0;
      dnack_q <= 1'b0;
      uack_q  <= 1'b0;
      unack_q <= 1'b0;
    end else begin
      money_q <= money_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < NUM_SLOTS; i++) cd_q[i] <= cd_d[i];
      dack_q  <= dack_d;
      dnack_q <= dnack_d;
      uack_q  <= uack_d;
      unack_q <= unack_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++)
      slot_ready[i] = (cd_q[i] == '0) && (money_q >= cost_tbl[i*MONEY_W +: MONEY_W]);
  end

  assign money         = money_q;
  assign level         = level_q;
  assign deploy_ack    = dack_q;
  assign deploy_nack   = dnack_q;
  assign upgrade_ack   = uack_q;
  assign upgrade_nack  = unack_q;
  assign upgrade_ready = upg_can;
  assign tick          = tick_ev && rst_n;

endmodule

// File: tb/tb_purse_deploy_ctrl.sv
// Directed bench for purse_deploy_ctrl: request results are queued as expected
// pulses and checked by an independent monitor; state is checked inline.
module tb_purse_deploy_ctrl;
  localparam int MONEY_W = 15, NUM_SLOTS = 6, SLOT_W = 3, LEVELS = 8, LVL_W = 3;
  localparam int CD_W = 8, TICK_DIV = 4, INC_BASE = 10, INC_STEP = 5;
  localparam logic [3:0] DACK = 4'b1000, DNACK = 4'b0100, UACK = 4'b0010, UNACK = 4'b0001;

  logic clk = 1'b0;
  logic rst_n, enable, start, deploy_req, upgrade_req;
  logic [SLOT_W-1:0] deploy_slot;
  logic [NUM_SLOTS*MONEY_W-1:0] cost_tbl;
  logic [NUM_SLOTS*CD_W-1:0] cd_tbl;
  logic [LEVELS*MONEY_W-1:0] max_tbl, upg_tbl;
  logic [MONEY_W-1:0] money;
  logic [LVL_W-1:0] level;
  logic deploy_ack, deploy_nack, upgrade_ack, upgrade_nack, upgrade_ready, tick;
  logic [NUM_SLOTS-1:0] slot_ready;

  int checks = 0;
  int errors = 0;
  int cur = 0;

  typedef struct {
    logic [3:0] pul;
    int money;
    int level;
  } exp_t;
  exp_t exp_q[$];

  int cost_v[NUM_SLOTS] = '{75, 5, 0, 200, 300, 400};
  int cd_v[NUM_SLOTS]   = '{3, 1, 5, 2, 2, 2};
  int max_v[LEVELS]     = '{150, 300, 150, 1000, 1000, 1000, 1000, 1000};
  int upg_v[LEVELS]     = '{100, 30, 0, 0, 0, 0, 0, 500};

  always #5 clk = ~clk;

  purse_deploy_ctrl #(
    .MONEY_W(MONEY_W), .NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W), .LEVELS(LEVELS),
    .LVL_W(LVL_W), .CD_W(CD_W), .TICK_DIV(TICK_DIV), .INC_BASE(INC_BASE), .INC_STEP(INC_STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
    .deploy_req(deploy_req), .deploy_slot(deploy_slot), .upgrade_req(upgrade_req),
    .cost_tbl(cost_tbl), .cd_tbl(cd_tbl), .max_tbl(max_tbl), .upg_tbl(upg_tbl),
    .money(money), .level(level), .deploy_ack(deploy_ack), .deploy_nack(deploy_nack),
    .upgrade_ack(upgrade_ack), .upgrade_nack(upgrade_nack), .slot_ready(slot_ready),
    .upgrade_ready(upgrade_ready), .tick(tick)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cur, act, req);
    end
  endfunction

  task automatic expect_pulse(logic [3:0] p, int m, int l);
    exp_t e;
    e.pul = p;
    e.money = m;
    e.level = l;
    exp_q.push_back(e);
  endtask

  task automatic cycle_to(int c);
    while (cur < c) begin
      @(posedge clk);
      #1;
      cur++;
    end
  endtask

  // monitor: any result pulse must match the oldest queued expectation
  always @(negedge clk) begin
    logic [3:0] pul;
    exp_t e;
    pul = {deploy_ack, deploy_nack, upgrade_ack, upgrade_nack};
    if ((|pul) === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse cycle=%0d got=%b expected=none", cur, pul);
      end else begin
        e = exp_q.pop_front();
        chk("result_pulses", 32'(pul), 32'(e.pul));
        chk("money_at_result", 32'(money), 32'(e.money));
        chk("level_at_result", 32'(level), 32'(e.level));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cur);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cost_tbl[i*MONEY_W +: MONEY_W] = MONEY_W'(cost_v[i]);
      cd_tbl[i*CD_W +: CD_W]         = CD_W'(cd_v[i]);
    end
    for (int i = 0; i < LEVELS; i++) begin
      max_tbl[i*MONEY_W +: MONEY_W] = MONEY_W'(max_v[i]);
      upg_tbl[i*MONEY_W +: MONEY_W] = MONEY_W'(upg_v[i]);
    end
    rst_n = 1'b0; enable = 1'b1; start = 1'b0;
    deploy_req = 1'b1; deploy_slot = '0; upgrade_req = 1'b1;

    // reset with requests high
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_money", 32'(money), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_pulses", 32'({deploy_ack, deploy_nack, upgrade_ack, upgrade_nack, tick}), 0);
    chk("rst_slot_ready", 32'(slot_ready), 32'(6'b000100));
    chk("rst_upgrade_ready", 32'(upgrade_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; deploy_req = 1'b0; upgrade_req = 1'b0;
    cur = 1;

    // income every 4th cycle, saturating at 150
    for (int c = 1; c <= 80; c++) begin
      int m;
      cycle_to(c);
      @(negedge clk);
      m = 10 * ((c - 1) / 4);
      chk("tick_phase", 32'(tick), 32'(c % 4 == 0));
      chk("money_income", 32'(money), (m > 150) ? 150 : m);
    end

    // deploy slot0 and cooldown
    cycle_to(81); deploy_req = 1'b1; deploy_slot = 3'd0; expect_pulse(DACK, 75, 0);
    cycle_to(82); deploy_req = 1'b0;
    @(negedge clk);
    chk("slot0_busy_after_deploy", 32'(slot_ready[0]), 0);
    cycle_to(83); deploy_req = 1'b1; expect_pulse(DNACK, 75, 0);
    cycle_to(84); deploy_req = 1'b0;
    cycle_to(92);
    @(negedge clk);
    chk("slot0_cd_last_tick", 32'(slot_ready[0]), 0);
    cycle_to(93); deploy_req = 1'b1; deploy_slot = 3'd1; expect_pulse(DACK, 100, 0);
    @(negedge clk);
    chk("slot0_ready_after_cd", 32'(slot_ready[0]), 1);
    chk("money_before_slot1", 32'(money), 105);

    // upgrades 0->1 and 1->2
    cycle_to(94); deploy_req = 1'b0; upgrade_req = 1'b1; expect_pulse(UACK, 0, 1);
    @(negedge clk);
    chk("upgrade_ready_at_100", 32'(upgrade_ready), 1);
    cycle_to(95); upgrade_req = 1'b0;
    cycle_to(101); upgrade_req = 1'b1; expect_pulse(UACK, 0, 2);
    cycle_to(102); upgrade_req = 1'b0;

    // zero-cost slot2 starts a 5-tick cooldown before the freeze
    cycle_to(130); deploy_req = 1'b1; deploy_slot = 3'd2; expect_pulse(DACK, 140, 2);
    cycle_to(131); deploy_req = 1'b0;

    // hold for 20 cycles with requests high
    cycle_to(133); enable = 1'b0; deploy_req = 1'b1; deploy_slot = 3'd0; upgrade_req = 1'b1;
    for (int c = 133; c <= 152; c++) begin
      cycle_to(c);
      @(negedge clk);
      chk("hold_money", 32'(money), 150);
      chk("hold_tick", 32'(tick), 0);
      chk("hold_slot2_cd", 32'(slot_ready[2]), 0);
    end
    cycle_to(153); enable = 1'b1; deploy_req = 1'b0; upgrade_req = 1'b0;
    for (int c = 153; c <= 156; c++) begin
      cycle_to(c);
      @(negedge clk);
      chk("tick_after_hold", 32'(tick), 32'(c == 156));
    end
    cycle_to(168);
    @(negedge clk);
    chk("slot2_cd_resumed", 32'(slot_ready[2]), 0);
    cycle_to(169); deploy_req = 1'b1; deploy_slot = 3'd2; expect_pulse(DACK, 150, 2);
    @(negedge clk);
    chk("slot2_ready_after_cd", 32'(slot_ready[2]), 1);
    chk("money_cap_level2", 32'(money), 150);

    // start pulse clears money, level, cooldowns and tick phase
    cycle_to(170); deploy_req = 1'b0; start = 1'b1;
    cycle_to(171); start = 1'b0;
    @(negedge clk);
    chk("start_money", 32'(money), 0);
    chk("start_level", 32'(level), 0);
    chk("start_slot_ready", 32'(slot_ready), 32'(6'b000100));
    cycle_to(173);
    @(negedge clk);
    chk("start_tick_pre", 32'(tick), 0);
    cycle_to(174);
    @(negedge clk);
    chk("start_tick_first", 32'(tick), 1);
    cycle_to(175);
    @(negedge clk);
    chk("start_first_income", 32'(money), 10);

    // deploy + upgrade in a tick cycle at money 100
    cycle_to(214); deploy_req = 1'b1; deploy_slot = 3'd0; upgrade_req = 1'b1;
    expect_pulse(DACK | UNACK, 35, 0);
    @(negedge clk);
    chk("collision_money_in", 32'(money), 100);
    chk("collision_tick", 32'(tick), 1);
    cycle_to(215); deploy_req = 1'b0; upgrade_req = 1'b0;

    // climb to level 7 with the request held, then one refusal
    cycle_to(243); upgrade_req = 1'b1; expect_pulse(UACK, 5, 1);
    @(negedge clk);
    chk("money_before_climb", 32'(money), 105);
    cycle_to(244); upgrade_req = 1'b0;
    cycle_to(251); upgrade_req = 1'b1; expect_pulse(UACK, 5, 2);
    cycle_to(252); expect_pulse(UACK, 5, 3);
    cycle_to(253); expect_pulse(UACK, 5, 4);
    cycle_to(254); expect_pulse(UACK, 35, 5);
    cycle_to(255); expect_pulse(UACK, 35, 6);
    cycle_to(256); expect_pulse(UACK, 35, 7);
    cycle_to(257); expect_pulse(UNACK, 35, 7);
    @(negedge clk);
    chk("level7_upgrade_ready", 32'(upgrade_ready), 0);
    cycle_to(258); upgrade_req = 1'b0;

    // slot indices beyond NUM_SLOTS are refused
    cycle_to(259); deploy_req = 1'b1; deploy_slot = 3'd7; expect_pulse(DNACK, 80, 7);
    cycle_to(260); deploy_slot = 3'd6; expect_pulse(DNACK, 80, 7);
    cycle_to(261); deploy_req = 1'b0;
    cycle_to(263);
    @(negedge clk);
    chk("results_outstanding", 32'(exp_q.size()), 0);
    chk("final_level", 32'(level), 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
